// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/line widths plus the L1/L2 scheduler state and port ids.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l1_line;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_SERVE_I = 3'd1,
        ARB_SERVE_D = 3'd2,
        ARB_RESP_I  = 3'd3,
        ARB_RESP_D  = 3'd4
    } lc3b_arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } lc3b_arb_port_t;

endpackage

// File: rtl/l1_l2_rr_scheduler_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the side not granted last.
module rr_pick2
    import lc3b_types::*;
(
    input  logic           req_i,
    input  logic           req_d,
    input  lc3b_arb_port_t last_grant,
    output logic           grant_valid,
    output lc3b_arb_port_t grant
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant       = ICACHE;
        if (req_i && req_d) begin
            grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
        end else if (req_d) begin
            grant = DCACHE;
        end
    end

endmodule

// File: rtl/l1_l2_rr_scheduler.sv
// Shares the single L2 port between icache and dcache: latches one winner, runs one L2 transaction,
// then hands the line back with a one-cycle registered response.
module l1_l2_rr_scheduler
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic                  icache_resp,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic                  dcache_resp,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic                  l2_resp,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    output logic                  busy
);

    lc3b_arb_state_t       state;
    lc3b_arb_port_t        last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  write_q;

    logic                  grant_valid;
    lc3b_arb_port_t        grant;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  serving;

    rr_pick2 u_pick (
        .req_i       (icache_read),
        .req_d       (dcache_read | dcache_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        grant_addr                  = (grant == ICACHE) ? icache_address : dcache_address;
        grant_addr[OFFSET_BITS-1:0] = '0;
    end

    // A dcache read+write collision latches as a write; the icache side can only ever read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= DCACHE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        state      <= (grant == ICACHE) ? ARB_SERVE_I : ARB_SERVE_D;
                        last_grant <= grant;
                        addr_q     <= grant_addr;
                        wdata_q    <= (grant == DCACHE) ? dcache_wdata : '0;
                        write_q    <= (grant == DCACHE) && dcache_write;
                    end
                end
                ARB_SERVE_I: begin
                    if (l2_resp) begin
                        rdata_q <= l2_rdata;
                        state   <= ARB_RESP_I;
                    end
                end
                ARB_SERVE_D: begin
                    if (l2_resp) begin
                        rdata_q <= l2_rdata;
                        state   <= ARB_RESP_D;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops the L2 strobes immediately.
    always_comb begin
        serving      = (state == ARB_SERVE_I) || (state == ARB_SERVE_D);
        l2_read      = serving && !write_q;
        l2_write     = serving && write_q;
        l2_address   = addr_q;
        l2_wdata     = wdata_q;
        icache_resp  = (state == ARB_RESP_I);
        dcache_resp  = (state == ARB_RESP_D);
        icache_rdata = icache_resp ? rdata_q : '0;
        dcache_rdata = dcache_resp ? rdata_q : '0;
        busy         = (state != ARB_IDLE);
    end

endmodule

// File: tb/tb_l1_l2_rr_scheduler.sv
// Directed self-checking bench for l1_l2_rr_scheduler: latency, arbitration order, reset abort and corner cases.
module tb_l1_l2_rr_scheduler;

    logic         clk;
    logic         rst;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic         icache_resp;
    logic [127:0] icache_rdata;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_address;
    logic [127:0] dcache_wdata;
    logic         dcache_resp;
    logic [127:0] dcache_rdata;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;
    logic         busy;

    int checks;
    int errors;

    l1_l2_rr_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_resp        (l2_resp),
        .l2_rdata       (l2_rdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [15:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [15:0] da, input logic [127:0] dwd);
        icache_read    = ir;
        icache_address = ia;
        dcache_read    = dr;
        dcache_write   = dw;
        dcache_address = da;
        dcache_wdata   = dwd;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_l2rd"}, l2_read, 0);
        checkOutput({tag, "_l2wr"}, l2_write, 0);
        checkOutput({tag, "_iresp"}, icache_resp, 0);
        checkOutput({tag, "_dresp"}, dcache_resp, 0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_W  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [127:0] LINE_R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] LINE_R2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);

        // Reset state
        step();
        step();
        checkIdle("rst");
        checkOutput("rst_addr", l2_address, 0);
        checkOutput("rst_wdata", l2_wdata, 0);
        checkOutput("rst_irdata", icache_rdata, 0);
        checkOutput("rst_drdata", dcache_rdata, 0);
        rst = 1'b0;
        #1;

        // Lone icache read with 5-cycle L2 latency
        applyStimulus(1'b1, 16'h1236, 1'b0, 1'b0, 16'h0, '0);
        step();
        checkOutput("li_l2rd", l2_read, 1);
        checkOutput("li_l2wr", l2_write, 0);
        checkOutput("li_addr", l2_address, 16'h1230);
        checkOutput("li_busy", busy, 1);
        for (int c = 0; c < 4; c++) step();
        checkOutput("li_hold", l2_read, 1);
        checkOutput("li_noresp", icache_resp, 0);
        l2_resp  = 1'b1;
        l2_rdata = LINE_A5;
        step();
        l2_resp  = 1'b0;
        l2_rdata = '0;
        checkOutput("li_iresp", icache_resp, 1);
        checkOutput("li_irdata", icache_rdata, LINE_A5);
        checkOutput("li_dresp", dcache_resp, 0);
        checkOutput("li_drdata", dcache_rdata, 0);
        checkOutput("li_l2rd_off", l2_read, 0);
        icache_read = 1'b0;
        step();
        checkIdle("li_done");

        // Simultaneous icache read and dcache write after reset: icache first
        pulseReset();
        applyStimulus(1'b1, 16'h2004, 1'b0, 1'b1, 16'h3458, LINE_W);
        step();
        checkOutput("tie_first_rd", l2_read, 1);
        checkOutput("tie_first_wr", l2_write, 0);
        checkOutput("tie_first_addr", l2_address, 16'h2000);
        l2_resp  = 1'b1;
        l2_rdata = LINE_R1;
        step();
        l2_resp  = 1'b0;
        checkOutput("tie_iresp", icache_resp, 1);
        checkOutput("tie_irdata", icache_rdata, LINE_R1);
        checkOutput("tie_dresp", dcache_resp, 0);
        icache_read = 1'b0;
        step();
        checkOutput("tie_gap", busy, 0);
        step();
        checkOutput("tie_d_wr", l2_write, 1);
        checkOutput("tie_d_rd", l2_read, 0);
        checkOutput("tie_d_addr", l2_address, 16'h3450);
        checkOutput("tie_d_wdata", l2_wdata, LINE_W);
        l2_resp  = 1'b1;
        l2_rdata = LINE_R2;
        step();
        l2_resp  = 1'b0;
        checkOutput("tie_dresp2", dcache_resp, 1);
        checkOutput("tie_drdata2", dcache_rdata, LINE_R2);
        checkOutput("tie_iresp2", icache_resp, 0);
        dcache_write = 1'b0;
        step();
        checkIdle("tie_done");

        // Continuous requests from both sides: I,D,I,D,I,D
        applyStimulus(1'b1, 16'h4008, 1'b1, 1'b0, 16'h500F, '0);
        for (int k = 0; k < 6; k++) begin
            logic expect_i;
            logic [127:0] line;
            expect_i = (k % 2 == 0);
            line     = 128'h1000 + 128'(k);
            step();
            checkOutput($sformatf("rr%0d_rd", k), l2_read, 1);
            checkOutput($sformatf("rr%0d_addr", k), l2_address, expect_i ? 16'h4000 : 16'h5000);
            l2_resp  = 1'b1;
            l2_rdata = line;
            step();
            l2_resp  = 1'b0;
            checkOutput($sformatf("rr%0d_iresp", k), icache_resp, expect_i);
            checkOutput($sformatf("rr%0d_dresp", k), dcache_resp, !expect_i);
            checkOutput($sformatf("rr%0d_irdata", k), icache_rdata, expect_i ? line : 128'h0);
            checkOutput($sformatf("rr%0d_drdata", k), dcache_rdata, expect_i ? 128'h0 : line);
            step();
            checkOutput($sformatf("rr%0d_idle", k), busy, 0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);

        // Reset during SERVE_D aborts the writeback
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h6000, LINE_W);
        step();
        checkOutput("ab_wr", l2_write, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ab_wr_drop", l2_write, 0);
        checkOutput("ab_busy", busy, 0);
        dcache_write = 1'b0;
        l2_resp      = 1'b1;
        step();
        l2_resp = 1'b0;
        rst     = 1'b0;
        #1;
        checkIdle("ab_held");
        step();
        checkIdle("ab_after");
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h7001, '0);
        step();
        checkOutput("ab_new_rd", l2_read, 1);
        checkOutput("ab_new_addr", l2_address, 16'h7000);
        l2_resp  = 1'b1;
        l2_rdata = LINE_R1;
        step();
        l2_resp  = 1'b0;
        checkOutput("ab_new_dresp", dcache_resp, 1);
        checkOutput("ab_new_drdata", dcache_rdata, LINE_R1);
        dcache_read = 1'b0;
        step();

        // Spurious l2_resp while idle
        l2_resp  = 1'b1;
        l2_rdata = LINE_R2;
        step();
        checkIdle("sp1");
        l2_resp = 1'b0;
        step();
        checkIdle("sp2");
        checkOutput("sp_irdata", icache_rdata, 0);

        // dcache read and write together: write wins
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h8123, LINE_R2);
        step();
        checkOutput("rw_wr", l2_write, 1);
        checkOutput("rw_rd", l2_read, 0);
        checkOutput("rw_addr", l2_address, 16'h8120);
        checkOutput("rw_wdata", l2_wdata, LINE_R2);
        l2_resp = 1'b1;
        step();
        l2_resp = 1'b0;
        checkOutput("rw_dresp", dcache_resp, 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
        step();
        checkIdle("rw_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
